// File: rtl/colour_table_arbiter_if.sv
// rtl/colour_table_arbiter_if.sv - request/response handshake bundle for one colour-table requester
interface colour_table_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/colour_table_arbiter.sv
// rtl/colour_table_arbiter.sv - two-requester colour-table read arbiter with 2-entry response FIFOs
// Optional starvation guard for requester 1 enabled by CT_ARB_STARVE_GUARD_EN.
module colour_table_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  aclk,
  input  logic                  areset,
  colour_table_arbiter_if.slave req0,
  colour_table_arbiter_if.slave req1,
  output logic [ADDR_WIDTH-1:0] ct_address,
  input  logic [DATA_WIDTH-1:0] ct_data
);

`ifdef CT_ARB_STARVE_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  logic [1:0]            req_valid, rsp_ready, inflight, head_valid, pop, space, ready, accept;
  logic [ADDR_WIDTH-1:0] req_addr [2];
  logic [DATA_WIDTH-1:0] fifo_mem [2][2];
  logic [DATA_WIDTH-1:0] head_data [2];
  logic [1:0]            occ [2];
  logic [1:0]            rd_ptr, wr_ptr;
  logic                  slot_valid, slot_owner;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [7:0]            starve_cnt;
  logic                  starve_hit;

  always_comb begin
    req_valid   = {req1.req_valid, req0.req_valid};
    rsp_ready   = {req1.rsp_ready, req0.rsp_ready};
    req_addr[0] = req0.req_addr;
    req_addr[1] = req1.req_addr;
  end

  // An in-flight slot landing while the head leaves keeps occupancy at one,
  // which is what lets a single requester stream one read per cycle.
  always_comb begin
    inflight     = '0;
    head_valid   = '0;
    pop          = '0;
    space        = '0;
    head_data[0] = '0;
    head_data[1] = '0;
    for (int i = 0; i < 2; i++) begin
      inflight[i]   = slot_valid && (slot_owner == 1'(i));
      head_valid[i] = (occ[i] != 2'd0);
      pop[i]        = head_valid[i] && rsp_ready[i];
      head_data[i]  = fifo_mem[i][rd_ptr[i]];
      space[i]      = ((3'(occ[i]) + 3'(inflight[i])) < 3'd2)
                      || (inflight[i] && (occ[i] == 2'd1) && pop[i]);
    end
  end

  assign starve_hit = GUARD_EN && (starve_cnt == 8'(STARVE_LIMIT)) && space[1];

  always_comb begin
    ready    = '0;
    ready[0] = !areset && space[0] && !(starve_hit && req_valid[1]);
    ready[1] = !areset && space[1] && (starve_hit || !(req_valid[0] && space[0]));
    accept   = req_valid & ready;

    ct_address = '0;
    if (!areset) begin
      if (accept[1])      ct_address = req_addr[1];
      else if (accept[0]) ct_address = req_addr[0];
      else                ct_address = last_addr;
    end

    req0.req_ready = ready[0];
    req1.req_ready = ready[1];
    req0.rsp_valid = !areset && head_valid[0];
    req1.rsp_valid = !areset && head_valid[1];
    req0.rsp_data  = (!areset && head_valid[0]) ? head_data[0] : '0;
    req1.rsp_data  = (!areset && head_valid[1]) ? head_data[1] : '0;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      slot_valid <= 1'b0;
      slot_owner <= 1'b0;
      last_addr  <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      occ[0]     <= '0;
      occ[1]     <= '0;
      starve_cnt <= '0;
    end else begin
      slot_valid <= |accept;
      slot_owner <= accept[1];
      if (|accept) last_addr <= ct_address;

      for (int i = 0; i < 2; i++) begin
        if (inflight[i]) begin
          fifo_mem[i][wr_ptr[i]] <= ct_data;
          wr_ptr[i]              <= ~wr_ptr[i];
        end
        if (pop[i]) rd_ptr[i] <= ~rd_ptr[i];
        occ[i] <= occ[i] + 2'(inflight[i]) - 2'(pop[i]);
      end

      if (accept[1] || !req_valid[1])  starve_cnt <= '0;
      else if (GUARD_EN && space[1])   starve_cnt <= starve_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_colour_table_arbiter.sv
// tb/tb_colour_table_arbiter.sv - self-checking bench for colour_table_arbiter (honours CT_ARB_STARVE_GUARD_EN)
module tb_colour_table_arbiter;
  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int LIMIT = 8;
`ifdef CT_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    int            vis;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] ct_address;
  logic [DW-1:0] ct_data = '0;

  int            checks = 0;
  int            errors = 0;
  ent_t          q [2][$];
  int            cyc = 0;
  int            starve = 0;
  int            acc_cnt [2] = '{0, 0};
  logic [AW-1:0] last_addr = '0;

  colour_table_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) p0 ();
  colour_table_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) p1 ();

  colour_table_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .aclk       (clk),
    .areset     (rst),
    .req0       (p0),
    .req1       (p1),
    .ct_address (ct_address),
    .ct_data    (ct_data)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    return a ^ 16'h7C0F;
  endfunction

  // Colour table port B: registered read, data one cycle after the address
  always @(posedge clk) ct_data <= rom(ct_address);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: per-requester queue of owed responses, each visible two cycles after accept
  always @(negedge clk) begin
    logic [1:0]    v, rr, vis, pop, space, rdy, acc;
    logic [AW-1:0] a [2];
    logic [DW-1:0] rd [2];
    logic [AW-1:0] exp_addr;
    ent_t          e;
    bit            hit;
    v    = {p1.req_valid, p0.req_valid};
    rr   = {p1.rsp_ready, p0.rsp_ready};
    a[0] = p0.req_addr;
    a[1] = p1.req_addr;
    if (rst) begin
      chk("rst_ready0", 32'(p0.req_ready), 32'd0);
      chk("rst_ready1", 32'(p1.req_ready), 32'd0);
      chk("rst_rsp0_valid", 32'(p0.rsp_valid), 32'd0);
      chk("rst_rsp1_valid", 32'(p1.rsp_valid), 32'd0);
      chk("rst_rsp0_data", 32'(p0.rsp_data), 32'd0);
      chk("rst_rsp1_data", 32'(p1.rsp_data), 32'd0);
      chk("rst_ct_address", 32'(ct_address), 32'd0);
      q[0].delete();
      q[1].delete();
      starve    = 0;
      last_addr = '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        vis[i]   = (q[i].size() > 0) && (q[i][0].vis <= cyc);
        pop[i]   = vis[i] && rr[i];
        space[i] = (q[i].size() < 2) || ((q[i].size() == 2) && (q[i][1].vis > cyc) && pop[i]);
        rd[i]    = vis[i] ? q[i][0].data : '0;
      end
      hit      = GUARD && (starve == LIMIT) && space[1];
      rdy[0]   = space[0] && !(hit && v[1]);
      rdy[1]   = space[1] && (hit || !(v[0] && space[0]));
      acc      = v & rdy;
      exp_addr = acc[1] ? a[1] : (acc[0] ? a[0] : last_addr);

      chk("ready0", 32'(p0.req_ready), 32'(rdy[0]));
      chk("ready1", 32'(p1.req_ready), 32'(rdy[1]));
      chk("rsp0_valid", 32'(p0.rsp_valid), 32'(vis[0]));
      chk("rsp1_valid", 32'(p1.rsp_valid), 32'(vis[1]));
      if (vis[0]) chk("rsp0_data", 32'(p0.rsp_data), 32'(rd[0]));
      if (vis[1]) chk("rsp1_data", 32'(p1.rsp_data), 32'(rd[1]));
      chk("ct_address", 32'(ct_address), 32'(exp_addr));

      for (int i = 0; i < 2; i++) begin
        if (pop[i]) void'(q[i].pop_front());
        if (acc[i]) begin
          e.data = rom(a[i]);
          e.vis  = cyc + 2;
          q[i].push_back(e);
          acc_cnt[i]++;
        end
      end
      if (acc[1] || !v[1]) starve = 0;
      else if (space[1])   starve++;
      if (|acc) last_addr = exp_addr;
    end
    cyc++;
  end

  task automatic drive(input bit v0, input logic [AW-1:0] a0, input bit r0,
                       input bit v1, input logic [AW-1:0] a1, input bit r1);
    p0.req_valid = v0;
    p0.req_addr  = a0;
    p0.rsp_ready = r0;
    p1.req_valid = v1;
    p1.req_addr  = a1;
    p1.rsp_ready = r1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int            s0, s1, idx;
    logic [DW-1:0] got [$];
    int            hits [$];

    // Reset with both requesters asking: everything must stay quiet
    rst = 1'b1;
    drive(1, 16'h1234, 1, 1, 16'h4321, 1);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("reset_ready0", 32'(p0.req_ready), 32'd0);
    chk("reset_ct_address", 32'(ct_address), 32'd0);

    // Single read, accepted in the first cycle out of reset
    next_cycle();
    rst = 1'b0;
    drive(1, 16'h0010, 1, 0, 16'h0000, 1);
    @(negedge clk);
    chk("first_ready0", 32'(p0.req_ready), 32'd1);
    chk("first_ct_address", 32'(ct_address), 32'h0010);
    next_cycle();
    drive(0, 16'h0000, 1, 0, 16'h0000, 1);
    @(negedge clk);
    chk("single_rsp_early", 32'(p0.rsp_valid), 32'd0);
    chk("ct_address_hold", 32'(ct_address), 32'h0010);
    next_cycle();
    @(negedge clk);
    chk("single_rsp_valid", 32'(p0.rsp_valid), 32'd1);
    chk("single_rsp_data", 32'(p0.rsp_data), 32'h7C1F);
    next_cycle();
    next_cycle();

    // Contention: both requesters valid every cycle
    s0 = acc_cnt[0];
    s1 = acc_cnt[1];
`ifdef CT_ARB_STARVE_GUARD_EN
    for (int k = 0; k < 27; k++) begin
      drive(1, 16'(16'h0100 + k), 1, 1, 16'(16'h0800 + k), 1);
      @(negedge clk);
      if (p1.req_valid && p1.req_ready) hits.push_back(k);
      next_cycle();
    end
    chk("guard_acc0", 32'(acc_cnt[0] - s0), 32'd24);
    chk("guard_acc1", 32'(acc_cnt[1] - s1), 32'd3);
    chk("guard_hits", 32'(hits.size()), 32'd3);
    for (int h = 0; h < hits.size(); h++) chk("guard_hit_cycle", 32'(hits[h]), 32'(8 + 9 * h));
`else
    for (int k = 0; k < 20; k++) begin
      drive(1, 16'(16'h0100 + k), 1, 1, 16'h0800, 1);
      @(negedge clk);
      chk("contention_ready1", 32'(p1.req_ready), 32'd0);
      next_cycle();
    end
    chk("contention_acc0", 32'(acc_cnt[0] - s0), 32'd20);
    chk("contention_acc1", 32'(acc_cnt[1] - s1), 32'd0);
`endif
    for (int k = 0; k < 4; k++) begin
      drive(0, 16'h0000, 1, 0, 16'h0000, 1);
      next_cycle();
    end

    // Backpressure on requester 1; requester 0 must remain unaffected
    idx = 0;
    for (int k = 0; k < 6; k++) begin
      drive(k >= 4, 16'h0B00, 1, idx < 4, 16'(16'h0A00 + idx), 0);
      @(negedge clk);
      if (k == 4) chk("indep_ready0", 32'(p0.req_ready), 32'd1);
      if (p1.req_valid && p1.req_ready) idx++;
      next_cycle();
    end
    chk("bp_accepted", 32'(idx), 32'd2);
    chk("bp_ready1_low", 32'(p1.req_ready), 32'd0);

    for (int k = 0; k < 20 && (idx < 4 || got.size() < 4); k++) begin
      drive(0, 16'h0000, 1, idx < 4, 16'(16'h0A00 + idx), 1);
      @(negedge clk);
      if (k == 0) chk("bp_pop_no_reuse", 32'(p1.req_ready), 32'd0);
      if (k == 1) chk("bp_reuse_next", 32'(p1.req_ready), 32'd1);
      if (p1.rsp_valid) got.push_back(p1.rsp_data);
      if (p1.req_valid && p1.req_ready) idx++;
      next_cycle();
    end
    chk("bp_total", 32'(idx), 32'd4);
    chk("bp_rsp_count", 32'(got.size()), 32'd4);
    for (int h = 0; h < got.size() && h < 4; h++) chk("bp_rsp_order", 32'(got[h]), 32'h760F - 32'(h));
    for (int k = 0; k < 4; k++) begin
      drive(0, 16'h0000, 1, 0, 16'h0000, 1);
      next_cycle();
    end

    // Reset one cycle after an accept: the response must never appear
    drive(1, 16'h0C00, 1, 0, 16'h0000, 1);
    @(negedge clk);
    chk("mid_accept", 32'(p0.req_ready), 32'd1);
    next_cycle();
    rst = 1'b1;
    drive(0, 16'h0000, 1, 0, 16'h0000, 1);
    @(negedge clk);
    chk("mid_rst_rsp0", 32'(p0.rsp_valid), 32'd0);
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid_post_rsp0", 32'(p0.rsp_valid), 32'd0);
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
